out_port_alloc: RTL and testbench
=================================

OUT_PORT_ALLOC -- requirements
Module: out_port_alloc

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- P, 7, router port count.
- FW, 64, flit width.
- B, 4, downstream buffer address width (depth 2^B).
REQ-002 Ports SHALL be as follows, one per line: name  direction  width  meaning.
- clk  input  1  sole clock.
- rst  input  1  synchronous, active-high reset.
- req  input  P  bit i: input queue i requests this output port.
- flit_in  input  P*FW  crossbar flits; input i occupies bits [i*FW+FW-1 : i*FW].
- grant  output  P  one-hot grant back to input queue i; all-zero when no grant.
- flit_out_wr  output  1  write strobe into the downstream input queue.
- flit_out  output  FW  registered flit to the downstream input queue.
- credit_in  input  1  downstream flit release pulse (one credit per cycle high).
- credit_cnt  output  B+1  current free downstream slots.
- credit_err  output  1  sticky flag: credit returned while the counter is already full.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high (ports clk, rst).

Function
REQ-004 grant SHALL be combinational from req, the round-robin pointer and credit_cnt in the same cycle.
REQ-005 grant SHALL be all-zero whenever credit_cnt==0 or req==0.
REQ-006 Grant selection SHALL be round-robin: pick the first set req bit at or after ptr, wrapping from P-1 to 0.
REQ-007 After a grant to input k, ptr SHALL become (k+1) mod P on the next edge; ptr SHALL be unchanged in cycles without a grant.
REQ-008 On a grant to input k, flit_in slice k SHALL be captured into flit_out and flit_out_wr SHALL be 1 in the next cycle (latency 1).
REQ-009 flit_out_wr SHALL be 0 in every cycle not preceded by a grant.
REQ-010 flit_out SHALL hold its last value when flit_out_wr is 0.
REQ-011 Credit counter update rules:
- grant without credit_in: credit_cnt decrements by 1.
- credit_in without grant: credit_cnt increments by 1.
- grant and credit_in in the same cycle: credit_cnt is unchanged.
REQ-012 credit_in with credit_cnt==2^B and no grant SHALL leave credit_cnt at 2^B and set credit_err.
REQ-013 credit_cnt SHALL never wrap below 0; REQ-005 guarantees no decrement at 0.
REQ-014 A requester holding req for consecutive cycles SHALL receive at most one grant per cycle; back-to-back grants to the same input are legal only when it is the sole requester.
REQ-015 The block SHALL NOT wait for a grant acknowledge: the input queue drops its req bit itself, one cycle after the grant.

Reset
REQ-016 While rst is high:
- credit_cnt = 2^B.
- ptr = 0.
- flit_out = 0.
- flit_out_wr = 0.
- credit_err = 0.
- grant = 0 (masked by rst).
REQ-017 Reset asserted mid-transfer SHALL discard the registered flit; flit_out_wr SHALL be 0 in the cycle after rst is sampled.

Configuration
REQ-018 Macro OUT_PORT_ALLOC_STATS_EN, when defined, SHALL add two 32-bit outputs, both cleared by rst and saturating at 2^32-1:
- flit_cnt: counts flit_out_wr cycles.
- stall_cnt: counts cycles with req!=0 and credit_cnt==0.
REQ-019 Without OUT_PORT_ALLOC_STATS_EN, neither port nor its counter logic SHALL exist; all other behaviour SHALL be identical.

Verification
REQ-020 Reset, then req=7'b0000001, flit_in slice0=64'hA5 -> grant=7'b0000001 same cycle; next cycle flit_out_wr=1, flit_out=64'hA5, credit_cnt=15.
REQ-021 req=7'b1111111 held 7 cycles, credit_in=1 every cycle -> grants 0,1,...,6 in order; credit_cnt stays 16.
REQ-022 Hold req=1, credit_in=0 -> 16 grants, then grant=0 and credit_cnt=0; one credit_in pulse -> exactly one further grant.
REQ-023 credit_cnt=16, credit_in=1, req=0 -> credit_cnt stays 16 and credit_err=1 until rst.
REQ-024 Grant to input 3, with rst asserted in the following cycle -> flit_out_wr=0, credit_cnt=16, ptr=0 after reset.
REQ-025 With OUT_PORT_ALLOC_STATS_EN: 20 cycles req=1, no credits -> flit_cnt=16, stall_cnt=4.

Source files
------------

// File: rtl/out_port_alloc.sv
// Output-port allocator for one router output.
// Picks one requesting input queue per cycle in round-robin order, but only
// while the downstream buffer has a free slot. The granted flit is registered
// toward the downstream queue. A credit counter tracks the free downstream
// slots. The optional macro OUT_PORT_ALLOC_STATS_EN adds two saturating
// 32-bit counters: flits written (flit_cnt) and cycles stalled for credits
// (stall_cnt).
module out_port_alloc #(
   parameter int P  = 7,
   parameter int FW = 64,
   parameter int B  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [P-1:0]      req,
   input  logic [P*FW-1:0]   flit_in,
   output logic [P-1:0]      grant,
   output logic              flit_out_wr,
   output logic [FW-1:0]     flit_out,
   input  logic              credit_in,
   output logic [B:0]        credit_cnt,
   output logic              credit_err
`ifdef OUT_PORT_ALLOC_STATS_EN
   ,
   output logic [31:0]       flit_cnt,
   output logic [31:0]       stall_cnt
`endif
);

   localparam int PW = (P > 1) ? $clog2(P) : 1;
   localparam logic [B:0] FULL = {1'b1, {B{1'b0}}};

   logic [PW-1:0] ptr;
   logic [PW-1:0] grant_idx;
   logic [PW:0]   cand;
   logic          found;
   logic [FW-1:0] sel_flit;

   // Round-robin search starting at ptr; a grant is blocked while in reset,
   // when no credit is left, or when no input is requesting.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      if (!rst && (credit_cnt != '0) && (req != '0)) begin
         for (int i = 0; i < P; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(P)) begin
               cand = cand - (PW+1)'(P);
            end
            if (!found && req[cand[PW-1:0]]) begin
               found     = 1'b1;
               grant_idx = cand[PW-1:0];
            end
         end
      end
      if (found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   // Crossbar slice belonging to the granted input.
   always_comb begin
      sel_flit = flit_in[FW*int'(grant_idx) +: FW];
   end

   // Pointer, output flit register, credit counter and sticky credit error.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= '0;
         flit_out    <= '0;
         flit_out_wr <= 1'b0;
         credit_cnt  <= FULL;
         credit_err  <= 1'b0;
      end else begin
         flit_out_wr <= found;
         if (found) begin
            flit_out <= sel_flit;
            ptr      <= (grant_idx == PW'(P-1)) ? '0 : grant_idx + 1'b1;
         end
         unique case ({found, credit_in})
            2'b10: credit_cnt <= credit_cnt - 1'b1;
            2'b01: begin
               if (credit_cnt == FULL) begin
                  credit_err <= 1'b1;
               end else begin
                  credit_cnt <= credit_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef OUT_PORT_ALLOC_STATS_EN
   // Saturating counters for flits written downstream and cycles stalled on credit.
   always_ff @(posedge clk) begin
      if (rst) begin
         flit_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (flit_out_wr && (flit_cnt != '1)) begin
            flit_cnt <= flit_cnt + 1'b1;
         end
         if ((req != '0) && (credit_cnt == '0) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end
`else
   // The statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_out_port_alloc.sv
// Scoreboard testbench for out_port_alloc.
// The stimulus process drives one cycle at a time and pushes the reference
// model's expectations into queues. The monitor pops and compares them: grant
// is checked before the edge, and the registered outputs after it.
module tb_out_port_alloc;

   localparam int P    = 7;
   localparam int FW   = 64;
   localparam int B    = 4;
   localparam int FULL = 1 << B;

   logic              clk = 1'b0;
   logic              rst;
   logic [P-1:0]      req;
   logic [P*FW-1:0]   flit_in;
   logic [P-1:0]      grant;
   logic              flit_out_wr;
   logic [FW-1:0]     flit_out;
   logic              credit_in;
   logic [B:0]        credit_cnt;
   logic              credit_err;

   typedef struct {
      logic          wr;
      logic [FW-1:0] flit;
      int            cnt;
      logic          err;
   } state_t;

   logic [P-1:0] exp_grant_q [$];
   state_t       exp_state_q [$];

   int checks_total  = 0;
   int checks_passed = 0;

   // Reference model state.
   int            m_credits = FULL;
   int            m_ptr     = 0;
   logic          m_err     = 1'b0;
   logic [FW-1:0] m_flit    = '0;

   out_port_alloc #(.P(P), .FW(FW), .B(B)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .flit_in     (flit_in),
      .grant       (grant),
      .flit_out_wr (flit_out_wr),
      .flit_out    (flit_out),
      .credit_in   (credit_in),
      .credit_cnt  (credit_cnt),
      .credit_err  (credit_err)
   );

   // 10-time-unit clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      checks_total++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         checks_passed++;
      end
   endtask

   // Drive one cycle of inputs, run the reference model, and queue the expectations.
   task automatic applyStimulus(input logic r, input logic [P-1:0] rq, input logic ci,
                                input logic [P*FW-1:0] fl);
      int     g;
      state_t s;
      @(negedge clk);
      #1;
      rst       = r;
      req       = rq;
      credit_in = ci;
      flit_in   = fl;
      g = -1;
      if (!r && m_credits > 0 && rq != '0) begin
         for (int k = 0; k < P; k++) begin
            if (g < 0 && rq[(m_ptr + k) % P]) g = (m_ptr + k) % P;
         end
      end
      exp_grant_q.push_back((g >= 0) ? P'(1 << g) : '0);
      if (r) begin
         m_credits = FULL;
         m_ptr     = 0;
         m_err     = 1'b0;
         m_flit    = '0;
         s.wr      = 1'b0;
      end else begin
         s.wr = (g >= 0);
         if (g >= 0) begin
            m_flit = fl[g*FW +: FW];
            m_ptr  = (g + 1) % P;
            if (!ci) m_credits = m_credits - 1;
         end else if (ci) begin
            if (m_credits == FULL) m_err = 1'b1;
            else m_credits = m_credits + 1;
         end
      end
      s.flit = m_flit;
      s.cnt  = m_credits;
      s.err  = m_err;
      exp_state_q.push_back(s);
   endtask

   function automatic logic [P*FW-1:0] rand_flits();
      logic [P*FW-1:0] v;
      for (int i = 0; i < P*FW/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Monitor: grant settles after the inputs change, registered outputs just after the edge.
   initial begin
      state_t s;
      forever begin
         @(negedge clk);
         #3;
         if (exp_grant_q.size() > 0) begin
            checkOutput("grant", FW'(grant), FW'(exp_grant_q.pop_front()));
         end
         @(posedge clk);
         #1;
         if (exp_state_q.size() > 0) begin
            s = exp_state_q.pop_front();
            checkOutput("flit_out_wr", FW'(flit_out_wr), FW'(s.wr));
            checkOutput("flit_out", flit_out, s.flit);
            checkOutput("credit_cnt", FW'(credit_cnt), FW'(s.cnt));
            checkOutput("credit_err", FW'(credit_err), FW'(s.err));
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      logic [P*FW-1:0] fl;
      logic [P-1:0]    rq;
      rst = 1'b1; req = '0; credit_in = 1'b0; flit_in = '0;
      applyStimulus(1'b1, '0, 1'b0, '0);
      applyStimulus(1'b1, '0, 1'b0, '0);

      // Single requester on input 0.
      fl = '0; fl[FW-1:0] = 64'hA5;
      applyStimulus(1'b0, 7'b0000001, 1'b0, fl);
      applyStimulus(1'b0, '0, 1'b0, fl);

      // All inputs requesting, with a credit returned every cycle.
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 7'b1111111, 1'b1, rand_flits());
      applyStimulus(1'b0, '0, 1'b1, '0);

      // Drain every credit, then return a single credit.
      applyStimulus(1'b1, '0, 1'b0, '0);
      for (int i = 0; i < 20; i++) applyStimulus(1'b0, 7'b0000001, 1'b0, rand_flits());
      applyStimulus(1'b0, 7'b0000001, 1'b1, rand_flits());
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 7'b0000001, 1'b0, rand_flits());

      // Credit overflow sets the sticky error flag.
      applyStimulus(1'b1, '0, 1'b0, '0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, '0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 7'b0000010, 1'b0, rand_flits());

      // Reset right after a grant to input 3.
      applyStimulus(1'b1, '0, 1'b0, '0);
      applyStimulus(1'b0, 7'b0001000, 1'b0, rand_flits());
      applyStimulus(1'b1, 7'b0001000, 1'b0, rand_flits());
      applyStimulus(1'b0, 7'b1111111, 1'b0, rand_flits());
      applyStimulus(1'b0, 7'b1111111, 1'b0, rand_flits());

      // Random traffic: credits plentiful first, then scarce.
      for (int i = 0; i < 400; i++) begin
         rq = ($urandom_range(0, 7) == 0) ? '0 : P'($urandom_range(0, (1 << P) - 1));
         applyStimulus(($urandom_range(0, 60) == 0), rq,
                       (i < 200) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 6) == 0),
                       rand_flits());
      end

      applyStimulus(1'b0, '0, 1'b0, '0);
      @(posedge clk);
      #3;
      checkOutput("grant_queue_drained", FW'(exp_grant_q.size()), '0);
      checkOutput("state_queue_drained", FW'(exp_state_q.size()), '0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
